// File: rtl/bus_req_queue_pkg.sv
// Shared definitions for the bus request queue: requester slots, unit IDs and the queue entry.
package bus_req_queue_pkg;

    localparam int unsigned NREQ = 11;
    localparam int unsigned IDW  = 4;
    localparam int unsigned ENTW = 2 * IDW;
    localparam int unsigned CNTW = 4;

    // Requester slot positions within req / ack / req_data
    localparam int unsigned SLOT_DMA = 10;
    localparam int unsigned SLOT_IE  = 9;
    localparam int unsigned SLOT_IO  = 8;
    localparam int unsigned SLOT_DER = 7;
    localparam int unsigned SLOT_DEW = 6;
    localparam int unsigned SLOT_DOR = 5;
    localparam int unsigned SLOT_DOW = 4;
    localparam int unsigned SLOT_B0  = 3;
    localparam int unsigned SLOT_B1  = 2;
    localparam int unsigned SLOT_B2  = 1;
    localparam int unsigned SLOT_B3  = 0;

    // Unit IDs carried in the src / dest fields
    localparam logic [IDW-1:0] ID_IE  = 4'h0;
    localparam logic [IDW-1:0] ID_IO  = 4'h1;
    localparam logic [IDW-1:0] ID_DER = 4'h4;
    localparam logic [IDW-1:0] ID_DOR = 4'h5;
    localparam logic [IDW-1:0] ID_DEW = 4'h6;
    localparam logic [IDW-1:0] ID_DOW = 4'h7;
    localparam logic [IDW-1:0] ID_B0  = 4'h8;
    localparam logic [IDW-1:0] ID_B1  = 4'h9;
    localparam logic [IDW-1:0] ID_B2  = 4'hA;
    localparam logic [IDW-1:0] ID_B3  = 4'hB;
    localparam logic [IDW-1:0] ID_DMA = 4'hC;

    typedef struct packed {
        logic [IDW-1:0] src;
        logic [IDW-1:0] dest;
    } brq_entry_t;

endpackage

// File: rtl/brq_arb.sv
// Fixed-priority one-hot arbiter: highest set request bit wins when enabled.
module brq_arb
    import bus_req_queue_pkg::*;
(
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt
);

    // Ascending scan so the highest index overwrites lower ones
    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (en && req[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_req_queue.sv
// In-order shift-register queue of bus requests; head is offered to the bus controller once its destination is free.
module bus_req_queue
    import bus_req_queue_pkg::*;
(
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NREQ*ENTW-1:0] req_data,
    input  logic [NREQ-1:0]      req,
    input  logic                 freeIE,
    input  logic                 freeIO,
    input  logic                 freeDE,
    input  logic                 freeDO,
    input  logic                 freeB0,
    input  logic                 freeB1,
    input  logic                 freeB2,
    input  logic                 freeB3,
    input  logic                 freeDMA,
    input  logic                 pull,
    output logic [NREQ-1:0]      ack,
    output logic                 req_ready,
    output logic [IDW-1:0]       send_out,
    output logic [IDW-1:0]       dest_out
);

    brq_entry_t      rout     [NREQ];
    brq_entry_t      rout_nxt [NREQ];
    logic [CNTW-1:0] count;
    logic [CNTW-1:0] count_nxt;
    logic [CNTW-1:0] wr_idx;
    logic            arb_en;
    logic            push;
    logic            pop;
    logic            head_valid;
    logic            head_free;
    brq_entry_t      head;
    brq_entry_t      win_entry;

    // Full queue never grants, even when the head pops the same cycle
    assign arb_en = !clr && (count < CNTW'(NREQ));

    brq_arb u_arb (
        .en  (arb_en),
        .req (req),
        .gnt (ack)
    );

    always_comb begin
        win_entry = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) win_entry = req_data[ENTW*i +: ENTW];
        end
    end

    assign head       = rout[0];
    assign head_valid = (count != '0);

    // Unmapped IDs count as free so a stray dest cannot wedge the queue
    always_comb begin
        head_free = 1'b1;
        case (head.dest)
            ID_IE:          head_free = freeIE;
            ID_IO:          head_free = freeIO;
            ID_DER, ID_DEW: head_free = freeDE;
            ID_DOR, ID_DOW: head_free = freeDO;
            ID_B0:          head_free = freeB0;
            ID_B1:          head_free = freeB1;
            ID_B2:          head_free = freeB2;
            ID_B3:          head_free = freeB3;
            ID_DMA:         head_free = freeDMA;
            default:        head_free = 1'b1;
        endcase
    end

    assign req_ready = head_valid && head_free;
    assign send_out  = head_valid ? head.src  : '0;
    assign dest_out  = head_valid ? head.dest : '0;

    assign push = |ack;
    assign pop  = pull && req_ready;

    // Shift toward the head on pop, then append the granted entry at the tail
    always_comb begin
        rout_nxt  = rout;
        count_nxt = count;
        wr_idx    = pop ? CNTW'(count - CNTW'(1)) : count;
        if (pop) begin
            for (int i = 0; i < NREQ - 1; i++) rout_nxt[i] = rout[i+1];
            rout_nxt[NREQ-1] = '0;
        end
        if (push) rout_nxt[wr_idx] = win_entry;
        case ({push, pop})
            2'b10:   count_nxt = CNTW'(count + CNTW'(1));
            2'b01:   count_nxt = CNTW'(count - CNTW'(1));
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
            for (int i = 0; i < NREQ; i++) rout[i] <= '0;
        end else begin
            count <= count_nxt;
            for (int i = 0; i < NREQ; i++) rout[i] <= rout_nxt[i];
        end
    end

endmodule

// File: tb/tb_bus_req_queue.sv
// Directed bench for bus_req_queue: reset, priority fill, full, head blocking, drain, push+pop, flush.
module tb_bus_req_queue;
    import bus_req_queue_pkg::*;

    logic            clk;
    logic            clr;
    logic [87:0]     req_data;
    logic [10:0]     req;
    logic            freeIE, freeIO, freeDE, freeDO;
    logic            freeB0, freeB1, freeB2, freeB3, freeDMA;
    logic            pull;
    logic [10:0]     ack;
    logic            req_ready;
    logic [3:0]      send_out;
    logic [3:0]      dest_out;

    int n_checks;
    int n_fail;

    logic [7:0] fill_tab [11];

    bus_req_queue dut (
        .clk       (clk),
        .clr       (clr),
        .req_data  (req_data),
        .req       (req),
        .freeIE    (freeIE),
        .freeIO    (freeIO),
        .freeDE    (freeDE),
        .freeDO    (freeDO),
        .freeB0    (freeB0),
        .freeB1    (freeB1),
        .freeB2    (freeB2),
        .freeB3    (freeB3),
        .freeDMA   (freeDMA),
        .pull      (pull),
        .ack       (ack),
        .req_ready (req_ready),
        .send_out  (send_out),
        .dest_out  (dest_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_frees(input logic v);
        freeIE = v; freeIO = v; freeDE = v; freeDO = v;
        freeB0 = v; freeB1 = v; freeB2 = v; freeB3 = v; freeDMA = v;
    endtask

    task automatic set_slot(input int s, input logic [7:0] v);
        req_data[8*s +: 8] = v;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        req = '1;
        pull = 1'b1;
        set_frees(1'b1);
        #1;
        n_checks++;
        if (ack !== 11'h000) begin n_fail++; $display("FAIL reset_ack: got %h want 000", ack); end
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        n_checks++;
        if ({send_out, dest_out} !== 8'h00) begin n_fail++; $display("FAIL reset_head: got %h want 00", {send_out, dest_out}); end
        next_cycle();
        clr = 1'b0;
        req = '0;
        pull = 1'b0;
        #1;
        n_checks++;
        if (dut.count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_priority_fill();
        logic [10:0] exp_ack;
        set_frees(1'b0);
        for (int s = 0; s < 11; s++) set_slot(s, fill_tab[10-s]);
        req = '1;
        for (int k = 0; k < 11; k++) begin
            exp_ack = '0;
            exp_ack[10-k] = 1'b1;
            #1;
            n_checks++;
            if (ack !== exp_ack) begin n_fail++; $display("FAIL fill_ack[%0d]: got %h want %h", k, ack, exp_ack); end
            next_cycle();
            req[10-k] = 1'b0;
        end
        #1;
        n_checks++;
        if (dut.count !== 4'd11) begin n_fail++; $display("FAIL fill_count: got %0d want 11", dut.count); end
        for (int i = 0; i < 11; i++) begin
            n_checks++;
            if (dut.rout[i] !== fill_tab[i]) begin n_fail++; $display("FAIL fill_rout[%0d]: got %h want %h", i, dut.rout[i], fill_tab[i]); end
        end
    endtask

    task automatic test_full();
        req[SLOT_B0] = 1'b1;
        #1;
        n_checks++;
        if (ack !== 11'h000) begin n_fail++; $display("FAIL full_ack: got %h want 000", ack); end
        next_cycle();
        n_checks++;
        if (dut.count !== 4'd11) begin n_fail++; $display("FAIL full_count: got %0d want 11", dut.count); end
        n_checks++;
        if (dut.rout[10] !== 8'hB1) begin n_fail++; $display("FAIL full_tail: got %h want b1", dut.rout[10]); end
    endtask

    task automatic test_head_blocking();
        pull = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL block_ready: got %b want 0", req_ready); end
        next_cycle();
        n_checks++;
        if (dut.count !== 4'd11) begin n_fail++; $display("FAIL block_count: got %0d want 11", dut.count); end
        freeIE = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL unblock_ready: got %b want 1", req_ready); end
        n_checks++;
        if ({send_out, dest_out} !== 8'hC0) begin n_fail++; $display("FAIL unblock_head: got %h want c0", {send_out, dest_out}); end
        n_checks++;
        if (ack !== 11'h000) begin n_fail++; $display("FAIL full_pop_ack: got %h want 000", ack); end
        next_cycle();
        req = '0;
        #1;
        n_checks++;
        if (dut.count !== 4'd10) begin n_fail++; $display("FAIL pop_count: got %0d want 10", dut.count); end
        n_checks++;
        if ({send_out, dest_out} !== 8'h08) begin n_fail++; $display("FAIL new_head: got %h want 08", {send_out, dest_out}); end
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL b0_busy_ready: got %b want 0", req_ready); end
    endtask

    task automatic test_drain();
        set_frees(1'b1);
        pull = 1'b1;
        for (int k = 1; k < 11; k++) begin
            #1;
            n_checks++;
            if ({req_ready, send_out, dest_out} !== {1'b1, fill_tab[k]})
                begin n_fail++; $display("FAIL drain[%0d]: got %b/%h want 1/%h", k, req_ready, {send_out, dest_out}, fill_tab[k]); end
            next_cycle();
        end
        pull = 1'b0;
        #1;
        n_checks++;
        if ({req_ready, send_out, dest_out} !== 9'h000) begin n_fail++; $display("FAIL drain_empty: got %h want 000", {req_ready, send_out, dest_out}); end
        n_checks++;
        if (dut.count !== 4'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_free_lookup();
        set_frees(1'b0);
        set_slot(SLOT_IO, 8'h12);
        req[SLOT_IO] = 1'b1;
        next_cycle();
        req = '0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL unmapped_dest_ready: got %b want 1", req_ready); end
        pull = 1'b1;
        next_cycle();
        pull = 1'b0;
        n_checks++;
        if (dut.count !== 4'd0) begin n_fail++; $display("FAIL unmapped_pop_count: got %0d want 0", dut.count); end
    endtask

    task automatic test_push_pop();
        set_frees(1'b1);
        set_slot(SLOT_IO, 8'h19);
        for (int s = SLOT_IO; s >= SLOT_DEW; s--) begin
            req = '0;
            req[s] = 1'b1;
            next_cycle();
        end
        req = '0;
        req[SLOT_B2] = 1'b1;
        set_slot(SLOT_B2, 8'hA9);
        pull = 1'b1;
        #1;
        n_checks++;
        if (ack !== 11'b000_0000_0010) begin n_fail++; $display("FAIL pushpop_ack: got %h want 002", ack); end
        n_checks++;
        if ({req_ready, send_out, dest_out} !== 9'h119) begin n_fail++; $display("FAIL pushpop_head: got %h want 119", {req_ready, send_out, dest_out}); end
        next_cycle();
        req = '0;
        pull = 1'b0;
        n_checks++;
        if (dut.count !== 4'd3) begin n_fail++; $display("FAIL pushpop_count: got %0d want 3", dut.count); end
        n_checks++;
        if ({dut.rout[0], dut.rout[1], dut.rout[2], dut.rout[3]} !== 32'h4A65A900)
            begin n_fail++; $display("FAIL pushpop_rout: got %h%h%h%h want 4a65a900", dut.rout[0], dut.rout[1], dut.rout[2], dut.rout[3]); end
    endtask

    task automatic test_clr_flush();
        req[SLOT_DMA] = 1'b1;
        clr = 1'b1;
        #1;
        n_checks++;
        if (ack !== 11'h000) begin n_fail++; $display("FAIL flush_ack: got %h want 000", ack); end
        next_cycle();
        clr = 1'b0;
        req = '0;
        n_checks++;
        if (dut.count !== 4'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", dut.count); end
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        fill_tab[0] = 8'hC0; fill_tab[1] = 8'h08; fill_tab[2]  = 8'h19;
        fill_tab[3] = 8'h4A; fill_tab[4] = 8'h65; fill_tab[5]  = 8'h5B;
        fill_tab[6] = 8'h7C; fill_tab[7] = 8'h84; fill_tab[8]  = 8'h95;
        fill_tab[9] = 8'hA0; fill_tab[10] = 8'hB1;
        req_data = '0;
        req      = '0;
        pull     = 1'b0;
        clr      = 1'b1;
        set_frees(1'b0);

        test_reset();
        test_priority_fill();
        test_full();
        test_head_blocking();
        test_drain();
        test_free_lookup();
        test_push_pop();
        test_clr_flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
